// File: rtl/adder_bist_checker.sv
// adder_bist_checker
// Self-test engine for an external combinational 16-bit adder. Each vector
// takes two cycles: DRIVE registers operands from a 32-bit Fibonacci LFSR,
// CHECK compares the adder's {c_out,s} against a golden 17-bit sum.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a run (IDLE only)
//   abort           terminate a run (DRIVE/CHECK only), partial results kept
//   a, b, c_in      registered operands to the adder under test
//   s, c_out        adder result
//   busy            run in progress
//   done, pass      run completed / completed with zero errors
//   err_count       mismatching vectors in the last run
//   first_fail_idx  index of the first mismatch, 16'hFFFF if none
module adder_bist_checker #(
    parameter int          N_VECTORS = 256,
    parameter logic [31:0] SEED      = 32'hACE10001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic        c_in,
    input  logic [15:0] s,
    input  logic        c_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_fail_idx
);

    localparam logic [31:0] LFSR_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [15:0] LAST_IDX  = 16'(N_VECTORS - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t      state;
    logic [31:0] lfsr;
    logic [15:0] idx;

    logic [16:0] expected;
    logic        mismatch;
    logic [15:0] err_next;
    logic [31:0] lfsr_next;

    always_comb begin
        expected  = {1'b0, a} + {1'b0, b} + {16'd0, c_in};
        mismatch  = (expected != {c_out, s});
        err_next  = mismatch ? err_count + 16'd1 : err_count;
        lfsr_next = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lfsr           <= LFSR_INIT;
            idx            <= 16'd0;
            a              <= 16'd0;
            b              <= 16'd0;
            c_in           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'd0;
            first_fail_idx <= 16'hFFFF;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= DRIVE;
                        lfsr           <= LFSR_INIT;
                        idx            <= 16'd0;
                        err_count      <= 16'd0;
                        first_fail_idx <= 16'hFFFF;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else begin
                        a     <= lfsr[31:16];
                        b     <= lfsr[15:0];
                        c_in  <= idx[0];
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    // abort wins over both the compare and run completion
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else begin
                        err_count <= err_next;
                        if (mismatch && first_fail_idx == 16'hFFFF)
                            first_fail_idx <= idx;
                        lfsr <= lfsr_next;
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == 16'd0);
                        end else begin
                            idx   <= idx + 16'd1;
                            state <= DRIVE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
